// File: rtl/filtros_pkg.sv
// Shared types and defaults for the port-B memory arbiter.
package filtros_pkg;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_DISP,
    REQ_LD,
    REQ_DBG
  } req_id_t;

  localparam int DEF_MAX_WAIT = 15;
  localparam int DEF_RD_LAT   = 1;
  localparam int STAT_W       = 16;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory port-B bundle for mem_port_arbiter.
// slave = the arbiter, master = requesters plus memory side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 8
);

  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_gnt;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;

  logic              ld_req;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_gnt;

  logic              dbg_req;
  logic [ADDR_W-1:0] dbg_addr;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [DATA_W-1:0] dbg_rdata;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  disp_req, disp_addr, ld_req, ld_addr, ld_wdata, dbg_req, dbg_addr, mem_q,
    output disp_gnt, disp_rvalid, disp_rdata, ld_gnt, dbg_gnt, dbg_rvalid, dbg_rdata,
           mem_address, mem_data, mem_wren
  );

  modport master (
    output disp_req, disp_addr, ld_req, ld_addr, ld_wdata, dbg_req, dbg_addr, mem_q,
    input  disp_gnt, disp_rvalid, disp_rdata, ld_gnt, dbg_gnt, dbg_rvalid, dbg_rdata,
           mem_address, mem_data, mem_wren
  );

endinterface

// File: rtl/mem_port_arbiter_read_tag_pipe.sv
// RD_LAT-deep shift register carrying the owner of each issued read
// so returning q_b data can be steered to the right requester.
module arb_read_tag_pipe
  import filtros_pkg::*;
#(
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic    clk,
  input  logic    rst,
  input  req_id_t i_tag,
  output req_id_t o_tag
);

  req_id_t r_tag [RD_LAT];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) r_tag[i] <= REQ_NONE;
    end else begin
      r_tag[0] <= i_tag;
      for (int i = 1; i < RD_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  assign o_tag = r_tag[RD_LAT-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Port-B arbiter: display fixed priority, loader/debug round-robin with
// starvation override. Optional grant statistics behind `ARB_STATS_EN.
module mem_port_arbiter
  import filtros_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 8,
  parameter int RD_LAT   = DEF_RD_LAT,
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.slave   bus
`ifdef ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]   stat_disp,
  output logic [STAT_W-1:0]   stat_ld,
  output logic [STAT_W-1:0]   stat_dbg,
  output logic [STAT_W-1:0]   stat_starve
`endif
);

  localparam int              WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  function automatic logic [WAIT_W-1:0] wait_next(input logic req, input logic gnt,
                                                  input logic [WAIT_W-1:0] cnt);
    if (!req || gnt) return '0;
    return (cnt == WAIT_MAX) ? cnt : cnt + 1'b1;
  endfunction

  req_id_t             r_rr_ptr;
  logic [WAIT_W-1:0]   r_ld_wait;
  logic [WAIT_W-1:0]   r_dbg_wait;
  logic                r_override_block;
  logic [ADDR_W-1:0]   r_last_addr;
  logic [DATA_W-1:0]   r_last_data;

  req_id_t             w_gnt_id;
  req_id_t             w_rr_pick;
  req_id_t             w_tag_in;
  req_id_t             w_tag_out;
  logic                w_ld_starved;
  logic                w_dbg_starved;
  logic                w_forced;
  logic [ADDR_W-1:0]   w_mem_addr;

  // Grants are gated by rst so requests seen during reset never issue.
  always_comb begin
    w_ld_starved  = bus.ld_req  && (r_ld_wait  == WAIT_MAX) && !r_override_block;
    w_dbg_starved = bus.dbg_req && (r_dbg_wait == WAIT_MAX) && !r_override_block;
    w_rr_pick     = (r_rr_ptr == REQ_DBG) ? REQ_DBG : REQ_LD;
    w_gnt_id      = REQ_NONE;
    w_forced      = 1'b0;
    if (!rst) begin
      w_gnt_id = REQ_NONE;
    end else if (w_ld_starved && w_dbg_starved) begin
      w_gnt_id = w_rr_pick;
      w_forced = 1'b1;
    end else if (w_ld_starved) begin
      w_gnt_id = REQ_LD;
      w_forced = 1'b1;
    end else if (w_dbg_starved) begin
      w_gnt_id = REQ_DBG;
      w_forced = 1'b1;
    end else if (bus.disp_req) begin
      w_gnt_id = REQ_DISP;
    end else if (bus.ld_req && bus.dbg_req) begin
      w_gnt_id = w_rr_pick;
    end else if (bus.ld_req) begin
      w_gnt_id = REQ_LD;
    end else if (bus.dbg_req) begin
      w_gnt_id = REQ_DBG;
    end
  end

  always_comb begin
    w_mem_addr = r_last_addr;
    case (w_gnt_id)
      REQ_DISP: w_mem_addr = bus.disp_addr;
      REQ_LD:   w_mem_addr = bus.ld_addr;
      REQ_DBG:  w_mem_addr = bus.dbg_addr;
      default:  w_mem_addr = r_last_addr;
    endcase
  end

  assign bus.disp_gnt    = (w_gnt_id == REQ_DISP);
  assign bus.ld_gnt      = (w_gnt_id == REQ_LD);
  assign bus.dbg_gnt     = (w_gnt_id == REQ_DBG);
  assign bus.mem_wren    = (w_gnt_id == REQ_LD);
  assign bus.mem_address = w_mem_addr;
  assign bus.mem_data    = (w_gnt_id == REQ_LD) ? bus.ld_wdata : r_last_data;

  assign w_tag_in = (w_gnt_id == REQ_DISP || w_gnt_id == REQ_DBG) ? w_gnt_id : REQ_NONE;

  arb_read_tag_pipe #(.RD_LAT(RD_LAT)) u_tag_pipe (
    .clk   (clk),
    .rst   (rst),
    .i_tag (w_tag_in),
    .o_tag (w_tag_out)
  );

  assign bus.disp_rvalid = (w_tag_out == REQ_DISP);
  assign bus.dbg_rvalid  = (w_tag_out == REQ_DBG);
  assign bus.disp_rdata  = bus.disp_rvalid ? bus.mem_q : '0;
  assign bus.dbg_rdata   = bus.dbg_rvalid  ? bus.mem_q : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rr_ptr         <= REQ_LD;
      r_ld_wait        <= '0;
      r_dbg_wait       <= '0;
      r_override_block <= 1'b0;
      r_last_addr      <= '0;
      r_last_data      <= '0;
    end else begin
      r_ld_wait        <= wait_next(bus.ld_req,  w_gnt_id == REQ_LD,  r_ld_wait);
      r_dbg_wait       <= wait_next(bus.dbg_req, w_gnt_id == REQ_DBG, r_dbg_wait);
      r_override_block <= w_forced;
      if (w_gnt_id == REQ_LD)       r_rr_ptr <= REQ_DBG;
      else if (w_gnt_id == REQ_DBG) r_rr_ptr <= REQ_LD;
      if (w_gnt_id != REQ_NONE)     r_last_addr <= w_mem_addr;
      if (w_gnt_id == REQ_LD)       r_last_data <= bus.ld_wdata;
    end
  end

`ifdef ARB_STATS_EN
  function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] v, input logic hit);
    return (hit && v != '1) ? v + 1'b1 : v;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_disp   <= '0;
      stat_ld     <= '0;
      stat_dbg    <= '0;
      stat_starve <= '0;
    end else begin
      stat_disp   <= stat_inc(stat_disp,   w_gnt_id == REQ_DISP);
      stat_ld     <= stat_inc(stat_ld,     w_gnt_id == REQ_LD);
      stat_dbg    <= stat_inc(stat_dbg,    w_gnt_id == REQ_DBG);
      stat_starve <= stat_inc(stat_starve, w_forced);
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed phases plus random traffic against
// a cycle-level reference of the arbitration rules and a small memory.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  import filtros_pkg::*;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 8;
  localparam int RD_LAT   = 1;
  localparam int MAX_WAIT = 15;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef ARB_STATS_EN
  logic [15:0] stat_disp, stat_ld, stat_dbg, stat_starve;
`endif

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef ARB_STATS_EN
    ,
    .stat_disp   (stat_disp),
    .stat_ld     (stat_ld),
    .stat_dbg    (stat_dbg),
    .stat_starve (stat_starve)
`endif
  );

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 37 + 5);
  endfunction

  // Memory model: 16 words indexed by address[3:0], registered q_b.
  logic [7:0] mem [16];
  logic       mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
      mem_init <= 1'b1;
    end else if (bus.mem_wren) begin
      mem[bus.mem_address[3:0]] <= bus.mem_data;
    end
    bus.mem_q <= mem[bus.mem_address[3:0]];
  end

  typedef struct {
    int         who;
    logic [7:0] data;
    int         due;
  } rd_t;

  int          m_ldw, m_dbw;
  bit          m_rr_dbg, m_ovr;
  logic [31:0] m_last_addr;
  logic [7:0]  m_last_data;
  logic [7:0]  shadow [16];
  rd_t         pend [$];
  int          cyc, last_win;
  int          n_disp, n_ld, n_dbg, n_forced;
  int          n_pass = 0;
  int          n_fail = 0;
  logic        s_disp_g, s_ld_g, s_dbg_g, s_wren, s_disp_rv, s_dbg_rv;
  logic [7:0]  s_wdata, s_disp_rd;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ldw = 0; m_dbw = 0; m_rr_dbg = 0; m_ovr = 0;
    m_last_addr = '0; m_last_data = '0;
    pend.delete();
    last_win = 0;
    n_disp = 0; n_ld = 0; n_dbg = 0; n_forced = 0;
  endtask

  // One clock of checking: predict the grant from the rules, compare, advance.
  task automatic step();
    int          win;
    bit          sl, sd, forced;
    logic [31:0] exp_addr;
    rd_t         r;
    bit          exp_dv, exp_bv;
    logic [7:0]  exp_dd, exp_bd;
    @(negedge clk);
    sl = bus.ld_req  && (m_ldw == MAX_WAIT) && !m_ovr;
    sd = bus.dbg_req && (m_dbw == MAX_WAIT) && !m_ovr;
    forced = sl | sd;
    if (sl && sd)                        win = m_rr_dbg ? 3 : 2;
    else if (sl)                         win = 2;
    else if (sd)                         win = 3;
    else if (bus.disp_req)               win = 1;
    else if (bus.ld_req && bus.dbg_req)  win = m_rr_dbg ? 3 : 2;
    else if (bus.ld_req)                 win = 2;
    else if (bus.dbg_req)                win = 3;
    else                                 win = 0;
    exp_addr = (win == 1) ? bus.disp_addr : (win == 2) ? bus.ld_addr :
               (win == 3) ? bus.dbg_addr : m_last_addr;

    chk("gnt_vec", {bus.disp_gnt, bus.ld_gnt, bus.dbg_gnt}, {win == 1, win == 2, win == 3});
    chk("mem_address", bus.mem_address, exp_addr);
    chk("mem_wren", bus.mem_wren, win == 2);
    chk("mem_data", bus.mem_data, (win == 2) ? bus.ld_wdata : m_last_data);

    exp_dv = 0; exp_bv = 0; exp_dd = '0; exp_bd = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      r = pend.pop_front();
      if (r.who == 1) begin exp_dv = 1; exp_dd = r.data; end
      else begin exp_bv = 1; exp_bd = r.data; end
    end
    chk("disp_rvalid", bus.disp_rvalid, exp_dv);
    chk("dbg_rvalid", bus.dbg_rvalid, exp_bv);
    if (exp_dv) chk("disp_rdata", bus.disp_rdata, exp_dd);
    if (exp_bv) chk("dbg_rdata", bus.dbg_rdata, exp_bd);

    s_disp_g = bus.disp_gnt; s_ld_g = bus.ld_gnt; s_dbg_g = bus.dbg_gnt;
    s_wren = bus.mem_wren; s_wdata = bus.mem_data;
    s_disp_rv = bus.disp_rvalid; s_disp_rd = bus.disp_rdata; s_dbg_rv = bus.dbg_rvalid;

    if (win == 1 || win == 3) begin
      r.who = win; r.data = shadow[exp_addr[3:0]]; r.due = cyc + RD_LAT;
      pend.push_back(r);
    end
    if (win == 2) shadow[bus.ld_addr[3:0]] = bus.ld_wdata;
    m_ldw = (bus.ld_req  && win != 2) ? ((m_ldw < MAX_WAIT) ? m_ldw + 1 : MAX_WAIT) : 0;
    m_dbw = (bus.dbg_req && win != 3) ? ((m_dbw < MAX_WAIT) ? m_dbw + 1 : MAX_WAIT) : 0;
    if (win == 2) m_rr_dbg = 1;
    else if (win == 3) m_rr_dbg = 0;
    m_ovr = forced;
    if (win != 0) m_last_addr = exp_addr;
    if (win == 2) m_last_data = bus.ld_wdata;
    if (win == 1) n_disp++;
    if (win == 2) n_ld++;
    if (win == 3) n_dbg++;
    if (forced) n_forced++;
    last_win = win;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycle_check();
    @(negedge clk);
    chk("rst_gnt", {bus.disp_gnt, bus.ld_gnt, bus.dbg_gnt}, 3'b000);
    chk("rst_wren", bus.mem_wren, 1'b0);
    chk("rst_addr", bus.mem_address, 32'h0);
    chk("rst_data", bus.mem_data, 8'h0);
    chk("rst_rvalid", {bus.disp_rvalid, bus.dbg_rvalid}, 2'b00);
    chk("rst_rdata", {bus.disp_rdata, bus.dbg_rdata}, 16'h0);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_zero();
    bus.disp_req = 0; bus.ld_req = 0; bus.dbg_req = 0;
  endtask

  task automatic drive_rand(input int pd, input int pl, input int pb);
    if (last_win == 1 || !bus.disp_req) begin
      bus.disp_req = ($urandom_range(99) < pd); bus.disp_addr = $urandom;
    end
    if (last_win == 2 || !bus.ld_req) begin
      bus.ld_req = ($urandom_range(99) < pl); bus.ld_addr = $urandom; bus.ld_wdata = 8'($urandom);
    end
    if (last_win == 3 || !bus.dbg_req) begin
      bus.dbg_req = ($urandom_range(99) < pb); bus.dbg_addr = $urandom;
    end
  endtask

  // Requests stay asserted; a granted requester moves to a fresh address.
  task automatic drive_hold();
    if (last_win == 1) bus.disp_addr = $urandom;
    if (last_win == 2) begin bus.ld_addr = $urandom; bus.ld_wdata = 8'($urandom); end
    if (last_win == 3) bus.dbg_addr = $urandom;
  endtask

  initial begin
    int  prev_who, who, nf;
    bit  prev_den;
    for (int i = 0; i < 16; i++) shadow[i] = init_val(i);
    cyc = 0;
    model_reset();
    bus.disp_req = 1; bus.disp_addr = 32'h5; bus.ld_req = 1; bus.ld_addr = 32'h7;
    bus.ld_wdata = 8'h3C; bus.dbg_req = 1; bus.dbg_addr = 32'h9;

    // Reset with requests present: nothing may issue.
    for (int i = 0; i < 3; i++) reset_cycle_check();
    drive_zero();
    rst = 1'b1;

    // Display-only reads of 0..3.
    for (int k = 0; k < 5; k++) begin
      bus.disp_req = (k < 4); bus.disp_addr = 32'(k);
      step();
      if (k < 4) chk("disp_only_gnt", s_disp_g, 1'b1);
      if (k > 0) begin
        chk("disp_only_rvalid", s_disp_rv, 1'b1);
        chk("disp_only_rdata", s_disp_rd, init_val(k - 1));
      end
    end

    // Loader and debug together: alternation starting with loader.
    drive_zero();
    bus.ld_req = 1; bus.dbg_req = 1; bus.ld_addr = $urandom; bus.dbg_addr = $urandom;
    bus.ld_wdata = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("alt_ld", s_ld_g, logic'(i % 2 == 0));
      chk("alt_dbg", s_dbg_g, logic'(i % 2 == 1));
      if (i % 2 == 0) begin
        chk("alt_wren", s_wren, 1'b1);
        chk("alt_wdata", s_wdata, 8'hA5);
      end
      drive_hold();
      bus.ld_wdata = 8'hA5;
    end
    drive_zero();
    step();

    // Continuous display with loader waiting: forced grant every 16th cycle.
    bus.disp_req = 1; bus.disp_addr = $urandom; bus.ld_req = 1; bus.ld_addr = $urandom;
    for (int i = 0; i < 48; i++) begin
      step();
      chk("starve_ld_slot", s_ld_g, logic'(i % 16 == 15));
      chk("starve_disp_slot", s_disp_g, logic'(i % 16 != 15));
      drive_hold();
    end

    // Display, loader and debug all continuous.
    bus.dbg_req = 1; bus.dbg_addr = $urandom;
    prev_who = 0; prev_den = 0; nf = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      chk("disp_double_deny", !s_disp_g && prev_den, 1'b0);
      prev_den = !s_disp_g;
      if (s_ld_g || s_dbg_g) begin
        who = s_ld_g ? 2 : 3;
        nf++;
        if (prev_who != 0) chk("forced_alternate", who != prev_who, 1'b1);
        prev_who = who;
      end
      drive_hold();
    end
    chk("forced_count_min", nf >= 3, 1'b1);
    drive_zero();
    step();
    step();

    // Debug read granted, then reset before its data returns.
    bus.dbg_req = 1; bus.dbg_addr = $urandom;
    step();
    chk("mid_dbg_gnt", s_dbg_g, 1'b1);
    rst = 1'b0;
    model_reset();
    bus.dbg_req = 0; bus.disp_req = 1; bus.disp_addr = $urandom; bus.ld_req = 1;
    reset_cycle_check();
    reset_cycle_check();
    bus.ld_req = 0;
    rst = 1'b1;
    step();
    chk("first_cycle_gnt", s_disp_g, 1'b1);
    chk("no_stale_dbg_rvalid", s_dbg_rv, 1'b0);
    drive_zero();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("no_stale_dbg_rvalid", s_dbg_rv, 1'b0);
    end

    // Random traffic in blocks of differing load.
    for (int blk = 0; blk < 6; blk++) begin
      int pd, pl, pb;
      pd = (blk % 3 == 0) ? 95 : (blk % 3 == 1) ? 50 : 10;
      pl = 20 + 15 * blk;
      pb = 90 - 12 * blk;
      for (int i = 0; i < 100; i++) begin
        drive_rand(pd, pl, pb);
        step();
      end
    end
    drive_zero();
    step();
    step();

`ifdef ARB_STATS_EN
    chk("stat_disp", stat_disp, 16'(n_disp));
    chk("stat_ld", stat_ld, 16'(n_ld));
    chk("stat_dbg", stat_dbg, 16'(n_dbg));
    chk("stat_starve", stat_starve, 16'(n_forced));
`endif

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
